// File: rtl/kv_front_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : kv_front_pkg                                           |
// | Description : Shared opcodes, FSM state encoding and beat-count      |
// |               helper for the KV request front end.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package kv_front_pkg;

  localparam int unsigned OP_INSERT = 1;
  localparam int unsigned OP_GET    = 2;
  localparam int unsigned OP_DELETE = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ALLOC_REQ  = 3'd1,
    ST_ALLOC_WAIT = 3'd2,
    ST_KEY        = 3'd3,
    ST_VALUE      = 3'd4,
    ST_DRAIN      = 3'd5
  } state_t;

  // Ceil(len / bpb) for a power-of-two bpb. Evaluated in 32 bits so the
  // rounding add cannot overflow for any 16-bit length.
  function automatic logic [31:0] calc_beats(input logic [31:0] len,
                                             input int unsigned bpb);
    int sh;
    sh = 0;
    for (int i = 0; i < 31; i++) begin
      if (bpb == (32'd1 << i)) sh = i;
    end
    return (len + (bpb - 32'd1)) >> sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kv_front_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : kv_front_dispatch                                      |
// | Description : KV request front end. Accepts meta/key/value streams,  |
// |               requests value storage from the pointer allocator and  |
// |               emits a key descriptor stream plus an addressed value  |
// |               write stream. Failed allocations drain their value     |
// |               beats; zero-length INSERTs and unknown ops are dropped |
// |               and counted.                                           |
// | Ports       : s_meta_*  request meta (op, byte length)               |
// |               s_key_*   request key                                  |
// |               s_val_*   request value beats                          |
// |               m_alloc_* / s_alloc_*  allocator request / response    |
// |               m_key_*   key descriptor to index/hash stage           |
// |               m_val_*   addressed value writes to value memory       |
// |               drop_count, busy  status                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module kv_front_dispatch
  import kv_front_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEY_WIDTH  = 64,
  parameter int PTR_WIDTH  = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int OP_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OP_WIDTH-1:0]   s_meta_op,
  input  logic [LEN_WIDTH-1:0]  s_meta_len,
  input  logic                  s_meta_valid,
  output logic                  s_meta_ready,
  input  logic [KEY_WIDTH-1:0]  s_key_data,
  input  logic                  s_key_valid,
  output logic                  s_key_ready,
  input  logic [DATA_WIDTH-1:0] s_val_data,
  input  logic                  s_val_valid,
  output logic                  s_val_ready,
  output logic [LEN_WIDTH:0]    m_alloc_len,
  output logic                  m_alloc_valid,
  input  logic                  m_alloc_ready,
  input  logic [PTR_WIDTH-1:0]  s_alloc_ptr,
  input  logic                  s_alloc_fail,
  input  logic                  s_alloc_valid,
  output logic                  s_alloc_ready,
  output logic [1:0]            m_key_op,
  output logic [PTR_WIDTH-1:0]  m_key_ptr,
  output logic                  m_key_fail,
  output logic [KEY_WIDTH-1:0]  m_key_data,
  output logic                  m_key_valid,
  input  logic                  m_key_ready,
  output logic [PTR_WIDTH-1:0]  m_val_addr,
  output logic [DATA_WIDTH-1:0] m_val_data,
  output logic                  m_val_last,
  output logic                  m_val_valid,
  input  logic                  m_val_ready,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int BW  = LEN_WIDTH + 1;

  state_t               state;
  logic [1:0]           op_q;
  logic                 drop_q;
  logic                 fail_q;
  logic [BW-1:0]        beats_q;
  logic [BW-1:0]        idx_q;
  logic [PTR_WIDTH-1:0] ptr_q;

  logic          key_load_ok;
  logic          val_load_ok;
  logic          meta_fire;
  logic          alloc_req_fire;
  logic          alloc_rsp_fire;
  logic          key_fire;
  logic          val_fire;
  logic          idx_last;
  logic          is_insert;
  logic          is_get_del;
  logic [BW-1:0] meta_beats;

  // An output register can take new data when empty or being emptied.
  assign key_load_ok = !m_key_valid || m_key_ready;
  assign val_load_ok = !m_val_valid || m_val_ready;

  assign s_meta_ready  = (state == ST_IDLE);
  assign m_alloc_valid = (state == ST_ALLOC_REQ);
  assign m_alloc_len   = beats_q;
  assign s_alloc_ready = (state == ST_ALLOC_WAIT);
  // Dropped keys are discarded, so they never wait on the descriptor register.
  assign s_key_ready   = (state == ST_KEY) && (drop_q || key_load_ok);
  assign s_val_ready   = (state == ST_DRAIN) || ((state == ST_VALUE) && val_load_ok);
  assign busy          = (state != ST_IDLE);

  assign meta_fire      = s_meta_valid && s_meta_ready;
  assign alloc_req_fire = m_alloc_valid && m_alloc_ready;
  assign alloc_rsp_fire = s_alloc_valid && s_alloc_ready;
  assign key_fire       = s_key_valid && s_key_ready;
  assign val_fire       = s_val_valid && s_val_ready;
  assign idx_last       = (idx_q == (beats_q - BW'(1)));

  assign is_insert  = (s_meta_op == OP_WIDTH'(OP_INSERT));
  assign is_get_del = (s_meta_op == OP_WIDTH'(OP_GET)) || (s_meta_op == OP_WIDTH'(OP_DELETE));
  assign meta_beats = BW'(calc_beats(32'(s_meta_len), BPB));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= 2'd0;
      drop_q     <= 1'b0;
      fail_q     <= 1'b0;
      beats_q    <= '0;
      idx_q      <= '0;
      ptr_q      <= '0;
      drop_count <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (meta_fire) begin
            op_q    <= s_meta_op[1:0];
            beats_q <= meta_beats;
            idx_q   <= '0;
            ptr_q   <= '0;
            fail_q  <= 1'b0;
            if (is_insert && (s_meta_len != '0)) begin
              drop_q <= 1'b0;
              state  <= ST_ALLOC_REQ;
            end else if (is_get_del) begin
              drop_q <= 1'b0;
              state  <= ST_KEY;
            end else begin
              drop_q <= 1'b1;
              state  <= ST_KEY;
            end
          end
        end
        ST_ALLOC_REQ: begin
          if (alloc_req_fire) state <= ST_ALLOC_WAIT;
        end
        ST_ALLOC_WAIT: begin
          if (alloc_rsp_fire) begin
            ptr_q  <= s_alloc_ptr;
            fail_q <= s_alloc_fail;
            state  <= ST_KEY;
          end
        end
        ST_KEY: begin
          if (key_fire) begin
            if (drop_q || (op_q != 2'(OP_INSERT))) state <= ST_IDLE;
            else if (fail_q)                       state <= ST_DRAIN;
            else                                   state <= ST_VALUE;
          end
        end
        ST_VALUE, ST_DRAIN: begin
          if (val_fire) begin
            idx_q <= idx_q + BW'(1);
            if (idx_last) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (key_fire && drop_q && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end

  // Key descriptor register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_key_valid <= 1'b0;
      m_key_op    <= 2'd0;
      m_key_ptr   <= '0;
      m_key_fail  <= 1'b0;
      m_key_data  <= '0;
    end else if (key_fire && !drop_q) begin
      m_key_valid <= 1'b1;
      m_key_op    <= op_q;
      m_key_ptr   <= ptr_q;
      m_key_fail  <= fail_q;
      m_key_data  <= s_key_data;
    end else if (m_key_ready) begin
      m_key_valid <= 1'b0;
    end
  end

  // Value write register; only VALUE transfers load it, DRAIN beats vanish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_val_valid <= 1'b0;
      m_val_addr  <= '0;
      m_val_data  <= '0;
      m_val_last  <= 1'b0;
    end else if (val_fire && (state == ST_VALUE)) begin
      m_val_valid <= 1'b1;
      m_val_addr  <= ptr_q + PTR_WIDTH'(idx_q);
      m_val_data  <= s_val_data;
      m_val_last  <= idx_last;
    end else if (m_val_ready) begin
      m_val_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kv_front_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_kv_front_dispatch                                   |
// | Description : Scoreboard bench for kv_front_dispatch. Expected       |
// |               allocator lengths, key descriptors and value writes    |
// |               are queued as stimulus is driven and compared as the   |
// |               DUT hands them over.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_kv_front_dispatch;

  localparam int DW  = 512;
  localparam int KW  = 64;
  localparam int PW  = 16;
  localparam int LW  = 16;
  localparam int OW  = 8;
  localparam int TMO = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [OW-1:0] s_meta_op;
  logic [LW-1:0] s_meta_len;
  logic          s_meta_valid, s_meta_ready;
  logic [KW-1:0] s_key_data;
  logic          s_key_valid, s_key_ready;
  logic [DW-1:0] s_val_data;
  logic          s_val_valid, s_val_ready;
  logic [LW:0]   m_alloc_len;
  logic          m_alloc_valid, m_alloc_ready;
  logic [PW-1:0] s_alloc_ptr;
  logic          s_alloc_fail, s_alloc_valid, s_alloc_ready;
  logic [1:0]    m_key_op;
  logic [PW-1:0] m_key_ptr;
  logic          m_key_fail;
  logic [KW-1:0] m_key_data;
  logic          m_key_valid, m_key_ready;
  logic [PW-1:0] m_val_addr;
  logic [DW-1:0] m_val_data;
  logic          m_val_last, m_val_valid, m_val_ready;
  logic [15:0]   drop_count;
  logic          busy;

  kv_front_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .s_meta_op(s_meta_op), .s_meta_len(s_meta_len),
    .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready),
    .s_key_data(s_key_data), .s_key_valid(s_key_valid), .s_key_ready(s_key_ready),
    .s_val_data(s_val_data), .s_val_valid(s_val_valid), .s_val_ready(s_val_ready),
    .m_alloc_len(m_alloc_len), .m_alloc_valid(m_alloc_valid), .m_alloc_ready(m_alloc_ready),
    .s_alloc_ptr(s_alloc_ptr), .s_alloc_fail(s_alloc_fail),
    .s_alloc_valid(s_alloc_valid), .s_alloc_ready(s_alloc_ready),
    .m_key_op(m_key_op), .m_key_ptr(m_key_ptr), .m_key_fail(m_key_fail),
    .m_key_data(m_key_data), .m_key_valid(m_key_valid), .m_key_ready(m_key_ready),
    .m_val_addr(m_val_addr), .m_val_data(m_val_data), .m_val_last(m_val_last),
    .m_val_valid(m_val_valid), .m_val_ready(m_val_ready),
    .drop_count(drop_count), .busy(busy)
  );

  typedef struct packed {
    logic [1:0]    op;
    logic [PW-1:0] ptr;
    logic          fail;
    logic [KW-1:0] key;
  } key_exp_t;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic          last;
    logic [DW-1:0] data;
  } val_exp_t;

  key_exp_t  key_q[$];
  val_exp_t  val_q[$];
  logic [LW:0] alloc_q[$];

  int checks   = 0;
  int failures = 0;
  int alloc_fires = 0, key_fires = 0, val_fires = 0, val_valid_cycles = 0;
  bit mon_en = 1'b1;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitors / scoreboard pops, sampled mid-cycle.
  key_exp_t ke;
  val_exp_t ve;
  bit       k_stall = 1'b0, v_stall = 1'b0;
  logic [82:0]   k_hold;
  logic [DW-1:0] v_hold_data;
  logic [PW:0]   v_hold_al;

  always @(negedge clk) begin
    if (!rst_n) begin
      k_stall = 1'b0;
      v_stall = 1'b0;
    end else if (mon_en) begin
      if (m_val_valid) val_valid_cycles++;
      if (m_alloc_valid && m_alloc_ready) begin
        alloc_fires++;
        if (alloc_q.size() == 0) check_eq("alloc_unexpected", 1, 0);
        else check_eq("alloc_len", m_alloc_len, alloc_q.pop_front());
      end
      if (k_stall) check_eq("key_stable", {m_key_valid, m_key_op, m_key_ptr, m_key_fail, m_key_data},
                            {1'b1, k_hold});
      if (v_stall) begin
        check_eq("val_stable_data", m_val_data, v_hold_data);
        check_eq("val_stable_addr", {m_val_valid, m_val_addr, m_val_last}, {1'b1, v_hold_al});
      end
      if (m_key_valid && m_key_ready) begin
        key_fires++;
        if (key_q.size() == 0) check_eq("key_unexpected", 1, 0);
        else begin
          ke = key_q.pop_front();
          check_eq("key_op", m_key_op, ke.op);
          check_eq("key_ptr", m_key_ptr, ke.ptr);
          check_eq("key_fail", m_key_fail, ke.fail);
          check_eq("key_data", m_key_data, ke.key);
        end
      end
      if (m_val_valid && m_val_ready) begin
        val_fires++;
        if (val_q.size() == 0) check_eq("val_unexpected", 1, 0);
        else begin
          ve = val_q.pop_front();
          check_eq("val_addr", m_val_addr, ve.addr);
          check_eq("val_last", m_val_last, ve.last);
          check_eq("val_data", m_val_data, ve.data);
        end
      end
      k_stall     = m_key_valid && !m_key_ready;
      k_hold      = {m_key_op, m_key_ptr, m_key_fail, m_key_data};
      v_stall     = m_val_valid && !m_val_ready;
      v_hold_data = m_val_data;
      v_hold_al   = {m_val_addr, m_val_last};
    end
  end

  task automatic drive_meta(input logic [OW-1:0] op, input logic [LW-1:0] len);
    int n = 0;
    s_meta_op = op; s_meta_len = len; s_meta_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_meta_ready) break;
      if (++n > TMO) begin check_eq("meta_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    s_meta_valid = 1'b0;
  endtask

  task automatic send_alloc(input logic [PW-1:0] ptr, input logic fail);
    int n = 0;
    s_alloc_ptr = ptr; s_alloc_fail = fail; s_alloc_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_alloc_ready) break;
      if (++n > TMO) begin check_eq("alloc_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    s_alloc_valid = 1'b0;
  endtask

  task automatic send_key(input logic [KW-1:0] k);
    int n = 0;
    s_key_data = k; s_key_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_key_ready) break;
      if (++n > TMO) begin check_eq("key_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    s_key_valid = 1'b0;
  endtask

  task automatic send_vals(input logic [LW:0] nb, input logic [PW-1:0] ptr, input bit expect_out);
    logic [DW-1:0] d;
    for (int i = 0; i < int'(nb); i++) begin
      int n = 0;
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
      if (expect_out) val_q.push_back('{ptr + PW'(i), (i == int'(nb) - 1), d});
      s_val_data = d; s_val_valid = 1'b1;
      forever begin
        @(negedge clk);
        if (s_val_ready) break;
        if (++n > TMO) begin check_eq("val_timeout", 0, 1); break; end
      end
      @(posedge clk); #1;
    end
    s_val_valid = 1'b0;
  endtask

  task automatic do_req(input logic [OW-1:0] op, input logic [LW-1:0] len,
                        input logic [PW-1:0] ptr, input logic fail, input logic [KW-1:0] k);
    logic [LW:0] beats;
    beats = ({1'b0, len} + 17'd63) >> 6;
    if (op == 8'd1 && len != 16'd0) begin
      alloc_q.push_back(beats);
      key_q.push_back('{2'd1, ptr, fail, k});
      drive_meta(op, len);
      send_alloc(ptr, fail);
      send_key(k);
      send_vals(beats, ptr, !fail);
    end else if (op == 8'd2 || op == 8'd3) begin
      key_q.push_back('{op[1:0], 16'h0, 1'b0, k});
      drive_meta(op, len);
      send_key(k);
    end else begin
      drive_meta(op, len);
      send_key(k);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy && !m_key_valid && !m_val_valid &&
          key_q.size() == 0 && val_q.size() == 0 && alloc_q.size() == 0) break;
      if (++n > 3000) begin check_eq("idle_timeout", 0, 1); break; end
    end
    check_eq("key_q_empty", key_q.size(), 0);
    check_eq("val_q_empty", val_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int a0, v0, k0, f0;

  initial begin
    rst_n = 1'b0;
    s_meta_op = '0; s_meta_len = '0; s_meta_valid = 1'b0;
    s_key_data = '0; s_key_valid = 1'b0;
    s_val_data = '0; s_val_valid = 1'b0;
    s_alloc_ptr = '0; s_alloc_fail = 1'b0; s_alloc_valid = 1'b0;
    m_alloc_ready = 1'b1; m_key_ready = 1'b1; m_val_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_key_valid", m_key_valid, 0);
    check_eq("rst_val_valid", m_val_valid, 0);
    check_eq("rst_alloc_valid", m_alloc_valid, 0);
    check_eq("rst_key_data", m_key_data, 0);
    check_eq("rst_val_addr", m_val_addr, 0);
    check_eq("rst_drop_count", drop_count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_meta_ready", s_meta_ready, 1);
    @(posedge clk); #1;

    // INSERT len=100 -> 2 beats at 0x0040.
    a0 = alloc_fires;
    do_req(8'd1, 16'd100, 16'h0040, 1'b0, 64'hDEAD_BEEF_0000_0001);
    wait_idle();
    check_eq("ins_alloc_count", alloc_fires - a0, 1);

    // GET with a 3-cycle key stall; no allocation, no value beats.
    a0 = alloc_fires; v0 = val_valid_cycles;
    m_key_ready = 1'b0;
    fork
      do_req(8'd2, 16'd0, 16'h0, 1'b0, 64'h1234);
      begin repeat (4) @(posedge clk); #1 m_key_ready = 1'b1; end
    join
    wait_idle();
    check_eq("get_no_alloc", alloc_fires - a0, 0);
    check_eq("get_no_val", val_valid_cycles - v0, 0);

    do_req(8'd3, 16'd0, 16'h0, 1'b0, 64'h5678_9ABC);
    wait_idle();

    // INSERT len=64 with allocation failure: one beat drained, nothing written.
    v0 = val_valid_cycles;
    do_req(8'd1, 16'd64, 16'h0080, 1'b1, 64'hFA11_0000_0000_0002);
    wait_idle();
    check_eq("fail_no_val", val_valid_cycles - v0, 0);
    check_eq("fail_val_ready_idle", s_val_ready, 0);

    // Address wrap-around.
    do_req(8'd1, 16'd130, 16'hFFFF, 1'b0, 64'h0000_0000_0000_0003);
    wait_idle();

    // Mid-request stall on both outputs.
    v0 = val_fires;
    fork
      do_req(8'd1, 16'd300, 16'h0200, 1'b0, 64'h0000_0000_0000_0004);
      begin
        int n = 0;
        while (val_fires < v0 + 2 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) check_eq("stall_timeout", 0, 1);
        @(posedge clk); #1;
        m_key_ready = 1'b0; m_val_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 m_key_ready = 1'b1; m_val_ready = 1'b1;
      end
    join
    wait_idle();
    check_eq("stall_beats", val_fires - v0, 5);

    // Maximum length, failed allocation: 1024 beats drained.
    v0 = val_valid_cycles;
    do_req(8'd1, 16'hFFFF, 16'h1000, 1'b1, 64'h0000_0000_0000_0005);
    wait_idle();
    check_eq("max_no_val", val_valid_cycles - v0, 0);
    check_eq("max_busy", busy, 0);

    // Unknown opcode and zero-length INSERT are dropped.
    k0 = key_fires; a0 = alloc_fires; f0 = val_fires;
    do_req(8'd7, 16'd10, 16'h0, 1'b0, 64'h7777);
    do_req(8'd1, 16'd0, 16'h0, 1'b0, 64'h8888);
    wait_idle();
    check_eq("drop_count", drop_count, 2);
    check_eq("drop_no_key", key_fires - k0, 0);
    check_eq("drop_no_alloc", alloc_fires - a0, 0);
    check_eq("drop_no_val", val_fires - f0, 0);

    // Reset while a value beat is stuck in VALUE.
    mon_en = 1'b0;
    m_val_ready = 1'b0;
    drive_meta(8'd1, 16'd200);
    send_alloc(16'h0010, 1'b0);
    send_key(64'h0000_0000_0000_0006);
    s_val_data = {16{32'hCAFE_F00D}};
    s_val_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst_busy", busy, 1);
    check_eq("pre_rst_val_valid", m_val_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_val_valid", m_val_valid, 0);
    check_eq("mid_rst_key_valid", m_key_valid, 0);
    check_eq("mid_rst_alloc_valid", m_alloc_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_drop_count", drop_count, 0);
    rst_n = 1'b1;
    s_val_valid = 1'b0;
    m_val_ready = 1'b1;
    key_q.delete(); val_q.delete(); alloc_q.delete();
    @(posedge clk); #1;
    check_eq("post_rst_val_valid", m_val_valid, 0);
    mon_en = 1'b1;

    // Recovery after reset.
    do_req(8'd1, 16'd64, 16'h0300, 1'b0, 64'h0000_0000_0000_0007);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
